// File: rtl/adc_axil_arbiter.sv
// adc_axil_arbiter: two-requester AXI4-Lite master, one access at a time; define ADC_ARB_RR_EN for round-robin, else requester 0 has fixed priority.
module adc_axil_arbiter #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic [1:0]                req_valid,
    input  logic [1:0]                req_write,
    input  logic [2*ADDR_WIDTH-1:0]   req_addr,
    input  logic [2*DATA_WIDTH-1:0]   req_wdata,
    output logic [1:0]                req_ready,
    output logic [1:0]                rsp_valid,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                M_AXI_AWPROT,
    output logic                      M_AXI_AWVALID,
    input  logic                      M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                      M_AXI_WVALID,
    input  logic                      M_AXI_WREADY,
    input  logic [1:0]                M_AXI_BRESP,
    input  logic                      M_AXI_BVALID,
    output logic                      M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                M_AXI_ARPROT,
    output logic                      M_AXI_ARVALID,
    input  logic                      M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                M_AXI_RRESP,
    input  logic                      M_AXI_RVALID,
    output logic                      M_AXI_RREADY
);
    typedef enum logic [2:0] {IDLE, WR, WB, RA, RD, RSP} state_t;
    state_t                r_state, w_next;
    logic                  r_owner, r_awvalid, r_wvalid;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr;
    logic [DATA_WIDTH-1:0] r_wdata, r_rdata;
    logic [1:0]            r_resp;
    logic                  w_win, w_accept;
`ifdef ADC_ARB_RR_EN
    logic                  r_pri;
`endif
    always_comb begin
`ifdef ADC_ARB_RR_EN
        w_win = (req_valid == 2'b11) ? r_pri : req_valid[1];
`else
        w_win = !req_valid[0] && req_valid[1];
`endif
        w_accept = (r_state == IDLE) && |req_valid;
        w_addr = (w_win ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0]) & ~ADDR_WIDTH'(3);
        req_ready = w_accept ? (w_win ? 2'b10 : 2'b01) : 2'b00;
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_accept ? (req_write[w_win] ? WR : RA) : IDLE;
            WR:      w_next = ((!r_awvalid || M_AXI_AWREADY) && (!r_wvalid || M_AXI_WREADY)) ? WB : WR;
            WB:      w_next = M_AXI_BVALID ? RSP : WB;
            RA:      w_next = M_AXI_ARREADY ? RD : RA;
            RD:      w_next = M_AXI_RVALID ? RSP : RD;
            default: w_next = IDLE;
        endcase
    end
    assign M_AXI_AWADDR  = r_addr;
    assign M_AXI_ARADDR  = r_addr;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_AWPROT  = '0;
    assign M_AXI_ARPROT  = '0;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_ARVALID = (r_state == RA);
    assign M_AXI_BREADY  = (r_state == WB);
    assign M_AXI_RREADY  = (r_state == RD);
    assign rsp_valid     = (r_state == RSP) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_rdata     = r_rdata;
    assign rsp_resp      = r_resp;
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state   <= IDLE;
            r_owner   <= 1'b0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_resp    <= '0;
`ifdef ADC_ARB_RR_EN
            r_pri     <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_owner   <= w_win;
                r_addr    <= w_addr;
                r_wdata   <= w_win ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
                r_awvalid <= req_write[w_win];
                r_wvalid  <= req_write[w_win];
                r_rdata   <= '0;
                r_resp    <= '0;
`ifdef ADC_ARB_RR_EN
                r_pri     <= !w_win;
`endif
            end
            // AW and W retire independently; either may complete first
            if (r_awvalid && M_AXI_AWREADY) r_awvalid <= 1'b0;
            if (r_wvalid && M_AXI_WREADY) r_wvalid <= 1'b0;
            if (r_state == WB && M_AXI_BVALID) r_resp <= M_AXI_BRESP;
            if (r_state == RD && M_AXI_RVALID) begin
                r_rdata <= M_AXI_RDATA;
                r_resp  <= M_AXI_RRESP;
            end
        end
    end
endmodule

// File: tb/tb_adc_axil_arbiter.sv
// tb_adc_axil_arbiter: requesters, AXI4-Lite slave and transaction-level reference model driven cycle by cycle.
module tb_adc_axil_arbiter;
    localparam int AW = 4;
    localparam int DW = 32;
    logic ACLK = 0, ARESET = 1;
    logic [1:0] req_valid = 0, req_write = 0, req_ready, rsp_valid, rsp_resp;
    logic [2*AW-1:0] req_addr = 0;
    logic [2*DW-1:0] req_wdata = 0;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0] awprot, arprot;
    logic awvalid, awready = 0, wvalid, wready = 0, bvalid = 0, bready, arvalid, arready = 0, rvalid = 0, rready;
    logic [DW-1:0] wdata, rdata = 0;
    logic [3:0] wstrb;
    logic [1:0] bresp = 0, rresp = 0;

    adc_axil_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    always #5 ACLK = ~ACLK;

    typedef struct packed {logic w; logic [AW-1:0] a; logic [DW-1:0] d;} cmd_t;
    cmd_t q0[$], q1[$], cur;
    bit [1:0] pres;
    bit busy, owner, last = 1, aw_p, w_p, ar_p, b_w, r_w, in_wr, rsp_due;
    int c_aw, c_w, c_b, c_ar, c_r;
    logic [1:0] err = 0, err_fix = 0;
    logic [DW-1:0] exp_rdata = 0;
    logic [DW-1:0] mem [4];
    bit rand_dly = 0, rand_gap = 0;
    int d_aw = 0, d_w = 0, d_b = 0, d_ar = 0, d_r = 0;
    int n_chk = 0, n_fail = 0, cyc = 0;
    int grant_cyc, rsp_cyc, cnt_awv, cnt_wv, cnt_rsp;
    logic [DW-1:0] last_rdata;
    logic [1:0] last_resp;
    logic [AW-1:0] last_araddr;
    bit glog[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic cmd_t head(input bit i);
        return i ? q1[0] : q0[0];
    endfunction

    function automatic bit win(input logic [1:0] v);
`ifdef ADC_ARB_RR_EN
        if (v == 2'b11) return !last;
`else
        if (v == 2'b11) return 1'b0;
`endif
        return v[1];
    endfunction

    task automatic tick(input bit rst);
        logic [1:0] exp_rr;
        cmd_t h;
        bit w;
        @(negedge ACLK);
        ARESET = rst;
        for (int i = 0; i < 2; i++)
            if (!pres[i] && (i == 0 ? q0.size() : q1.size()) != 0 && (!rand_gap || $urandom_range(1) == 1)) pres[i] = 1;
        for (int i = 0; i < 2; i++) begin
            if (pres[i]) h = head(i[0]);
            else begin
                h.w = 1'($urandom);
                h.a = AW'($urandom);
                h.d = $urandom;
            end
            req_valid[i] = pres[i] && !rst;
            req_write[i] = h.w;
            req_addr[i*AW +: AW] = h.a;
            req_wdata[i*DW +: DW] = h.d;
        end
        awready = aw_p && c_aw == 0;
        wready  = w_p && c_w == 0;
        bvalid  = b_w && c_b == 0;
        bresp   = bvalid ? err : 2'($urandom);
        arready = ar_p && c_ar == 0;
        rvalid  = r_w && c_r == 0;
        rdata   = rvalid ? mem[cur.a[3:2]] : $urandom;
        rresp   = rvalid ? err : 2'($urandom);
        #1;
        exp_rr = (!busy && req_valid != 0) ? (win(req_valid) ? 2'b10 : 2'b01) : 2'b00;
        if (!rst) begin
            chk("req_ready", req_ready, exp_rr);
            chk("rsp_valid", rsp_valid, rsp_due ? (owner ? 2'b10 : 2'b01) : 2'b00);
            if (rsp_due) begin
                chk("rsp_rdata", rsp_rdata, exp_rdata);
                chk("rsp_resp", rsp_resp, err);
            end
            chk("valids", {awvalid, wvalid, arvalid, bready, rready}, {aw_p, w_p, ar_p, b_w, r_w});
            if (aw_p) chk("awaddr", awaddr, cur.a & 4'hC);
            if (w_p) chk("wdata", wdata, cur.d);
            if (ar_p) chk("araddr", araddr, cur.a & 4'hC);
            chk("strb_prot", {wstrb, awprot, arprot}, {4'hF, 6'h0});
        end
        if (rsp_valid != 0) begin
            last_rdata = rsp_rdata;
            last_resp = rsp_resp;
            rsp_cyc = cyc;
            cnt_rsp++;
        end
        if (arvalid) last_araddr = araddr;
        if (awvalid) cnt_awv++;
        if (wvalid) cnt_wv++;
        if (rst) begin
            {busy, aw_p, w_p, ar_p, b_w, r_w, in_wr, rsp_due} = '0;
            last = 1;
        end else begin
            if (rsp_due) begin
                rsp_due = 0;
                busy = 0;
            end
            if (b_w) begin
                if (bvalid) begin
                    b_w = 0;
                    rsp_due = 1;
                    if (err == 0) mem[cur.a[3:2]] = cur.d;
                end else c_b--;
            end
            if (r_w) begin
                if (rvalid) begin
                    r_w = 0;
                    rsp_due = 1;
                    exp_rdata = mem[cur.a[3:2]];
                end else c_r--;
            end
            if (aw_p) begin if (awready) aw_p = 0; else c_aw--; end
            if (w_p) begin if (wready) w_p = 0; else c_w--; end
            if (ar_p) begin
                if (arready) begin
                    ar_p = 0;
                    r_w = 1;
                end else c_ar--;
            end
            if (in_wr && !aw_p && !w_p) begin
                in_wr = 0;
                b_w = 1;
            end
            if (exp_rr != 0) begin
                w = exp_rr[1];
                cur = w ? q1.pop_front() : q0.pop_front();
                pres[w] = 0;
                owner = w;
                busy = 1;
                last = w;
                glog.push_back(w);
                grant_cyc = cyc;
                if (rand_dly) begin
                    c_aw = $urandom_range(3); c_w = $urandom_range(3); c_b = $urandom_range(3);
                    c_ar = $urandom_range(3); c_r = $urandom_range(3);
                    err = ($urandom_range(5) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
                end else begin
                    c_aw = d_aw; c_w = d_w; c_b = d_b; c_ar = d_ar; c_r = d_r;
                    err = err_fix;
                end
                exp_rdata = 0;
                if (cur.w) begin
                    aw_p = 1;
                    w_p = 1;
                    in_wr = 1;
                end else ar_p = 1;
            end
        end
        cyc++;
    endtask

    task automatic run(input int limit);
        int k = 0;
        while ((q0.size() != 0 || q1.size() != 0 || busy || pres != 0) && k < limit) begin
            tick(0);
            k++;
        end
        chk("timeout", k >= limit, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] g;
        for (int i = 0; i < 4; i++) mem[i] = 0;
        repeat (3) tick(1);
        tick(0);
        chk("rst_addr", {awaddr, araddr, wdata}, 0);
        chk("rst_rsp", {rsp_rdata, rsp_resp}, 0);
        chk("rst_ctl", {awvalid, wvalid, bready, arvalid, rready, req_ready, rsp_valid}, 0);
        // zero-wait write then read of the same register
        q0.push_back(cmd_t'{1'b1, 4'h0, 32'h1});
        run(50);
        chk("wr_latency", rsp_cyc - grant_cyc, 3);
        q0.push_back(cmd_t'{1'b0, 4'h0, 32'h0});
        run(50);
        chk("rd_latency", rsp_cyc - grant_cyc, 3);
        chk("rd_data", last_rdata, 32'h1);
        chk("rd_resp", last_resp, 0);
        // both requesters contend; reset first so the pointer favours requester 0
        tick(1);
        glog.delete();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(cmd_t'{1'b1, 4'h4, 32'hA5A5A5A5});
            q1.push_back(cmd_t'{1'b1, 4'h8, 32'h5A5A5A5A});
        end
        run(200);
        g = 0;
        foreach (glog[k]) if (k < 8) g[k] = glog[k];
        chk("grant_count", glog.size(), 8);
`ifdef ADC_ARB_RR_EN
        chk("grant_order", g, 8'hAA);
`else
        chk("grant_order", g, 8'hF0);
`endif
        // AWREADY held off for 3 cycles, WREADY immediate
        d_aw = 3;
        cnt_awv = 0; cnt_wv = 0; cnt_rsp = 0;
        q0.push_back(cmd_t'{1'b1, 4'hC, 32'hDEADBEEF});
        run(50);
        chk("awvalid_cycles", cnt_awv, 4);
        chk("wvalid_cycles", cnt_wv, 1);
        chk("aw_delay_rsp", cnt_rsp, 1);
        d_aw = 0;
        err_fix = 2'b10;
        q1.push_back(cmd_t'{1'b0, 4'hC, 32'h0});
        run(50);
        chk("slverr_resp", last_resp, 2'b10);
        chk("slverr_data", last_rdata, 32'hDEADBEEF);
        err_fix = 0;
        q0.push_back(cmd_t'{1'b0, 4'h7, 32'h0});
        run(50);
        chk("araddr_mask", last_araddr, 4'h4);
        chk("masked_data", last_rdata, 32'hA5A5A5A5);
        // reset while waiting for B
        d_b = 5;
        q0.push_back(cmd_t'{1'b1, 4'h0, 32'h12345678});
        begin
            int k = 0;
            while (!b_w && k < 50) begin
                tick(0);
                k++;
            end
            chk("reach_wb", b_w, 1);
        end
        tick(1);
        cnt_rsp = 0;
        tick(0);
        chk("rst_mid_ctl", {awvalid, wvalid, bready, arvalid, rready, req_ready, rsp_valid}, 0);
        d_b = 0;
        repeat (5) tick(0);
        chk("rst_no_rsp", cnt_rsp, 0);
        glog.delete();
        q1.push_back(cmd_t'{1'b0, 4'h0, 32'h0});
        run(50);
        chk("post_rst_grant", glog.size(), 1);
        chk("post_rst_rsp", cnt_rsp, 1);
        chk("post_rst_data", last_rdata, 32'h1);
        // random traffic, random slave stalls and error responses
        rand_dly = 1;
        rand_gap = 1;
        for (int i = 0; i < 150; i++) begin
            q0.push_back(cmd_t'{1'($urandom), 4'($urandom), $urandom});
            q1.push_back(cmd_t'{1'($urandom), 4'($urandom), $urandom});
        end
        run(20000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
